// File: rtl/pipeline_hazard_ctrl.sv
// Data-hazard controller for a 5-stage pipeline without forwarding: tracks in-flight
// destination registers and stalls the ID instruction while a source is still pending.
module pipeline_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int WB_SPLIT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   idValid,
  input  logic [REG_AW-1:0]      idRs,
  input  logic [REG_AW-1:0]      idRt,
  input  logic                   idUsesRs,
  input  logic                   idUsesRt,
  input  logic                   idRegWrite,
  input  logic [REG_AW-1:0]      idDestReg,
  input  logic                   flush,
  output logic                   stall,
  output logic                   issue,
  output logic                   hazardRs,
  output logic                   hazardRt,
  output logic [2**REG_AW-1:0]   pendingMask,
  output logic [CNT_W-1:0]       stallCycles
);

  localparam int NREG = 2**REG_AW;
  // With a split-cycle regfile the WB entry is already readable, so it is not checked.
  localparam int NCHK = DEPTH - WB_SPLIT;

  logic [DEPTH-1:0]  sb_v_r;
  logic [REG_AW-1:0] sb_dest_r [DEPTH];
  logic [CNT_W-1:0]  cnt_r;
  logic              hit_rs_s;
  logic              hit_rt_s;
  logic              hazard_rs_s;
  logic              hazard_rt_s;
  logic              stall_s;
  logic              issue_s;
  logic [NREG-1:0]   pending_s;

  function automatic logic [NREG-1:0] onehot(input logic [REG_AW-1:0] r);
    onehot = {{(NREG-1){1'b0}}, 1'b1} << r;
  endfunction

  // Compare ID sources against checked scoreboard entries and build the pending mask.
  always_comb begin
    hit_rs_s  = 1'b0;
    hit_rt_s  = 1'b0;
    pending_s = {NREG{1'b0}};
    for (int k = 0; k < NCHK; k++) begin
      hit_rs_s = hit_rs_s | (sb_v_r[k] & (sb_dest_r[k] == idRs));
      hit_rt_s = hit_rt_s | (sb_v_r[k] & (sb_dest_r[k] == idRt));
    end
    for (int k = 0; k < DEPTH; k++) begin
      pending_s = pending_s | (sb_v_r[k] ? onehot(sb_dest_r[k]) : {NREG{1'b0}});
    end
    hazard_rs_s = idValid & idUsesRs & (idRs != {REG_AW{1'b0}}) & hit_rs_s;
    hazard_rt_s = idValid & idUsesRt & (idRt != {REG_AW{1'b0}}) & hit_rt_s;
    stall_s     = (hazard_rs_s | hazard_rt_s) & ~flush;
    issue_s     = idValid & ~stall_s & ~flush;
  end

  // Scoreboard always advances; stalls and flushes push a bubble into the EX slot.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sb_v_r <= {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        sb_dest_r[k] <= {REG_AW{1'b0}};
      end
    end else begin
      sb_v_r[0]    <= issue_s & idRegWrite & (idDestReg != {REG_AW{1'b0}});
      sb_dest_r[0] <= issue_s ? idDestReg : {REG_AW{1'b0}};
      for (int k = 1; k < DEPTH; k++) begin
        sb_v_r[k]    <= sb_v_r[k-1];
        sb_dest_r[k] <= sb_dest_r[k-1];
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign stall       = stall_s;
  assign issue       = issue_s;
  assign hazardRs    = hazard_rs_s;
  assign hazardRt    = hazard_rt_s;
  assign pendingMask = pending_s;
  assign stallCycles = cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expectations
// (counter narrowed to 4 bits to reach saturation quickly).
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        resetN;
  logic        idValid;
  logic [4:0]  idRs;
  logic [4:0]  idRt;
  logic        idUsesRs;
  logic        idUsesRt;
  logic        idRegWrite;
  logic [4:0]  idDestReg;
  logic        flush;
  logic        stall;
  logic        issue;
  logic        hazardRs;
  logic        hazardRt;
  logic [31:0] pendingMask;
  logic [3:0]  stallCycles;

  int checks = 0;
  int errors = 0;
  int n_stall;

  pipeline_hazard_ctrl #(.REG_AW(5), .DEPTH(3), .WB_SPLIT(1), .CNT_W(4)) dut (
    .clk(clk), .resetN(resetN), .idValid(idValid), .idRs(idRs), .idRt(idRt),
    .idUsesRs(idUsesRs), .idUsesRt(idUsesRt), .idRegWrite(idRegWrite),
    .idDestReg(idDestReg), .flush(flush), .stall(stall), .issue(issue),
    .hazardRs(hazardRs), .hazardRt(hazardRt), .pendingMask(pendingMask),
    .stallCycles(stallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic rw, input logic [4:0] dest);
    idValid    = v;
    idRs       = rs;
    idRt       = rt;
    idUsesRs   = urs;
    idUsesRt   = urt;
    idRegWrite = rw;
    idDestReg  = dest;
    flush      = 1'b0;
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    resetN = 1'b0;
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    #2;
    check_val("rst_stall", {31'd0, stall}, 32'd0);
    check_val("rst_pmask", pendingMask, 32'd0);
    check_val("rst_cnt", {28'd0, stallCycles}, 32'd0);
    check_val("rst_issue", {31'd0, issue}, 32'd1);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    idle(1);

    // Back-to-back dependent pair: two stall cycles, issue on the third.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8);
    check_val("t2_prod_stall", {31'd0, stall}, 32'd0);
    tick();
    drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd10);
    check_val("t2_stall1", {31'd0, stall}, 32'd1);
    check_val("t2_hazrs", {31'd0, hazardRs}, 32'd1);
    check_val("t2_pmask", pendingMask, 32'h0000_0100);
    check_val("t2_noissue", {31'd0, issue}, 32'd0);
    tick();
    check_val("t2_stall2", {31'd0, stall}, 32'd1);
    tick();
    check_val("t2_stall3", {31'd0, stall}, 32'd0);
    check_val("t2_issue", {31'd0, issue}, 32'd1);
    check_val("t2_cnt", {28'd0, stallCycles}, 32'd2);
    tick();
    idle(3);

    // Distance 2 stalls once on rt; distance 3 (WB) does not stall.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9);
    tick();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd11);
    check_val("t3_indep", {31'd0, stall}, 32'd0);
    tick();
    drive(1'b1, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 5'd0);
    check_val("t3_d2_stall", {31'd0, stall}, 32'd1);
    check_val("t3_d2_hazrt", {31'd0, hazardRt}, 32'd1);
    tick();
    check_val("t3_d2_issue", {31'd0, issue}, 32'd1);
    check_val("t3_cnt", {28'd0, stallCycles}, 32'd3);
    tick();
    idle(3);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd12);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    tick();
    drive(1'b1, 5'd0, 5'd12, 1'b0, 1'b1, 1'b0, 5'd0);
    check_val("t3_d3_stall", {31'd0, stall}, 32'd0);
    check_val("t3_d3_hazrt", {31'd0, hazardRt}, 32'd0);
    check_val("t3_d3_pmask", pendingMask, 32'h0000_1000);
    tick();
    idle(3);

    // Writes to $0 and non-writing instructions never create hazards.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7);
    check_val("t4_rs0_stall", {31'd0, stall}, 32'd0);
    check_val("t4_rs0_pmask", pendingMask, 32'd0);
    tick();
    drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    check_val("t4_nowr_stall", {31'd0, stall}, 32'd0);
    check_val("t4_nowr_pmask", pendingMask, 32'd0);
    tick();
    idle(3);

    // Flush overrides a detected hazard and drops the ID instruction.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd13);
    tick();
    drive(1'b1, 5'd13, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    check_val("t5_pre_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    #1;
    check_val("t5_fl_stall", {31'd0, stall}, 32'd0);
    check_val("t5_fl_issue", {31'd0, issue}, 32'd0);
    tick();
    idle(0);
    check_val("t5_pmask", pendingMask, 32'h0000_2000);
    check_val("t5_cnt", {28'd0, stallCycles}, 32'd3);
    idle(3);

    // Self-dependent stream stalls 20 of 30 cycles and saturates the counter.
    drive(1'b1, 5'd14, 5'd0, 1'b1, 1'b0, 1'b1, 5'd14);
    n_stall = 0;
    for (int i = 0; i < 30; i++) begin
      if (stall) n_stall++;
      tick();
    end
    check_val("t6_nstall", n_stall, 32'd20);
    check_val("t6_sat", {28'd0, stallCycles}, 32'd15);
    tick();
    check_val("t6_mid_stall", {31'd0, stall}, 32'd1);
    #2;
    resetN = 1'b0;
    #1;
    check_val("t6_rst_stall", {31'd0, stall}, 32'd0);
    check_val("t6_rst_cnt", {28'd0, stallCycles}, 32'd0);
    check_val("t6_rst_pmask", pendingMask, 32'd0);
    check_val("t6_rst_issue", {31'd0, issue}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
